// File: rtl/spi_pkg.sv
// Shared constants for the SPI mode-0 slave: default frame width and bit-counter sizing.
package spi_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned CNT_W      = $clog2(DEF_DATA_W);

    function automatic int unsigned bitcnt_w(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser followed by a history flop and registered rise/fall pulses.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   rise_q;
    logic                   fall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            hist_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            hist_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
            fall_q <= ~sync_q[SYNC_STAGES-1] & hist_q;
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_interface.sv
// SPI mode-0 slave, MSB first. Define SPI_LOOPBACK_EN to echo the last received byte on miso
// instead of the running count of received bytes.
module spi_interface
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = spi_pkg::DEF_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              ssel_,
    input  logic              mosi,
    output logic              miso,
    output logic              ssel_active,
    output logic              ssel_endmessage,
    output logic [DATA_W-1:0] byte_data_recieved,
    output logic              led
);

    localparam int unsigned BCW = bitcnt_w(DATA_W);

    logic sck_rise, sck_fall;
    logic ssel_sync, ssel_start;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (sck),
        .sync_o (),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ssel_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (ssel_),
        .sync_o (ssel_sync),
        .rise_o (ssel_endmessage),
        .fall_o (ssel_start)
    );

    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   mosi_s;

    // The oldest received bit is never observed, so only DATA_W-1 bits are kept.
    logic [DATA_W-2:0] rx_q, rx_d;
    logic [BCW-1:0]    bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0] byte_q, byte_d;
    logic              led_q, led_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] tx_byte;

`ifdef SPI_LOOPBACK_EN
    assign tx_byte = byte_q;
`else
    logic [DATA_W-1:0] txcnt_q, txcnt_d;
    assign tx_byte = txcnt_q;
`endif

    assign mosi_s      = mosi_q[SYNC_STAGES-1];
    assign ssel_active = ~ssel_sync;

    always_comb begin
        rx_d     = rx_q;
        bitcnt_d = bitcnt_q;
        byte_d   = byte_q;
        led_d    = led_q;
        tx_d     = tx_q;
`ifndef SPI_LOOPBACK_EN
        txcnt_d  = txcnt_q;
`endif
        if (!ssel_active) begin
            bitcnt_d = '0;
        end else if (sck_rise) begin
            rx_d = {rx_q[DATA_W-3:0], mosi_s};
            if (bitcnt_q == BCW'(DATA_W-1)) begin
                bitcnt_d = '0;
                byte_d   = {rx_q, mosi_s};
                led_d    = mosi_s;
`ifndef SPI_LOOPBACK_EN
                txcnt_d  = txcnt_q + DATA_W'(1);
`endif
            end else begin
                bitcnt_d = bitcnt_q + BCW'(1);
            end
        end

        if (ssel_start) begin
            tx_d = tx_byte;
        end else if (sck_fall && ssel_active) begin
            tx_d = (bitcnt_q == '0) ? tx_byte : {tx_q[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_q   <= '0;
            rx_q     <= '0;
            bitcnt_q <= '0;
            byte_q   <= '0;
            led_q    <= 1'b0;
            tx_q     <= '0;
`ifndef SPI_LOOPBACK_EN
            txcnt_q  <= '0;
`endif
        end else begin
            mosi_q   <= {mosi_q[SYNC_STAGES-2:0], mosi};
            rx_q     <= rx_d;
            bitcnt_q <= bitcnt_d;
            byte_q   <= byte_d;
            led_q    <= led_d;
            tx_q     <= tx_d;
`ifndef SPI_LOOPBACK_EN
            txcnt_q  <= txcnt_d;
`endif
        end
    end

    assign miso               = ssel_active & tx_q[DATA_W-1];
    assign byte_data_recieved = byte_q;
    assign led                = led_q;

endmodule

// File: tb/tb_spi_interface.sv
// Scoreboard bench for spi_interface: a bit-banged SPI master drives frames while monitors
// compare received bytes, end-of-message values and sampled miso bytes against queued expectations.
`timescale 1ns/1ps
module tb_spi_interface;

    logic       clk = 1'b0;
    logic       rst;
    logic       sck, ssel_, mosi;
    logic       miso, ssel_active, ssel_endmessage, led;
    logic [7:0] byte_data_recieved;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_chg_q[$];
    logic [7:0] exp_end_q[$];
    logic [7:0] exp_miso_q[$];
    logic [7:0] obs_miso_q[$];
    logic [7:0] msg_q[$];

    logic [7:0] m_cnt  = 8'h00;
    logic [7:0] m_last = 8'h00;

    spi_interface #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk                (clk),
        .rst                (rst),
        .sck                (sck),
        .ssel_              (ssel_),
        .mosi               (mosi),
        .miso               (miso),
        .ssel_active        (ssel_active),
        .ssel_endmessage    (ssel_endmessage),
        .byte_data_recieved (byte_data_recieved),
        .led                (led)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every change of {byte, led} must match the next queued completed byte.
    logic [8:0] prev_out = 9'h000;
    always @(negedge clk) begin
        logic [8:0] cur;
        logic [7:0] e;
        cur = {byte_data_recieved, led};
        if (cur !== prev_out) begin
            if (exp_chg_q.size() == 0) begin
                check("unexpected_rx_change", {23'd0, cur}, {23'd0, prev_out});
            end else begin
                e = exp_chg_q.pop_front();
                check("rx_byte", {24'd0, byte_data_recieved}, {24'd0, e});
                check("led", {31'd0, led}, {31'd0, e[0]});
            end
            prev_out = cur;
        end
    end

    // Monitor: value presented at each end-of-message pulse.
    always @(negedge clk) begin
        logic [7:0] e;
        if (ssel_endmessage === 1'b1) begin
            if (exp_end_q.size() == 0) begin
                check("unexpected_endmessage", 32'd1, 32'd0);
            end else begin
                e = exp_end_q.pop_front();
                check("end_byte", {24'd0, byte_data_recieved}, {24'd0, e});
            end
        end
    end

    // Monitor: bytes the master sampled from miso.
    always @(negedge clk) begin
        logic [7:0] e, o;
        while (obs_miso_q.size() > 0 && exp_miso_q.size() > 0) begin
            e = exp_miso_q.pop_front();
            o = obs_miso_q.pop_front();
            check("miso_byte", {24'd0, o}, {24'd0, e});
        end
    end

    task automatic xfer(input logic [7:0] d, input int n, output logic [7:0] rd);
        rd = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = d[7-i];
            repeat (5) @(negedge clk);
            sck = 1'b1;
            rd[7-i] = miso;
            repeat (5) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic send_msg();
        logic [7:0] rd;
        ssel_ = 1'b0;
        repeat (10) @(negedge clk);
        check("ssel_active_in_msg", {31'd0, ssel_active}, 32'd1);
        foreach (msg_q[j]) begin
`ifdef SPI_LOOPBACK_EN
            exp_miso_q.push_back(m_last);
`else
            exp_miso_q.push_back(m_cnt);
`endif
            if (msg_q[j] != m_last) exp_chg_q.push_back(msg_q[j]);
            m_last = msg_q[j];
            m_cnt  = m_cnt + 8'd1;
            xfer(msg_q[j], 8, rd);
            obs_miso_q.push_back(rd);
        end
        repeat (5) @(negedge clk);
        exp_end_q.push_back(m_last);
        ssel_ = 1'b1;
        repeat (10) @(negedge clk);
        check("ssel_active_idle", {31'd0, ssel_active}, 32'd0);
        msg_q.delete();
    endtask

    initial begin
        logic [7:0] rd;
        rst = 1'b1; sck = 1'b0; ssel_ = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_ssel_active", {31'd0, ssel_active}, 32'd0);
        check("rst_endmessage", {31'd0, ssel_endmessage}, 32'd0);
        check("rst_byte", {24'd0, byte_data_recieved}, 32'd0);
        check("rst_led", {31'd0, led}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_ssel_active", {31'd0, ssel_active}, 32'd0);

        msg_q.push_back(8'hF0);
        send_msg();

        msg_q.push_back(8'h01); msg_q.push_back(8'hA5);
        send_msg();

        msg_q.push_back(8'h7E);
        send_msg();

        // Partial frame: five bits then deselect, byte must be discarded.
        ssel_ = 1'b0;
        repeat (10) @(negedge clk);
        xfer(8'hA8, 5, rd);
        repeat (5) @(negedge clk);
        exp_end_q.push_back(m_last);
        ssel_ = 1'b1;
        repeat (10) @(negedge clk);

        msg_q.push_back(8'h3C);
        send_msg();

        // Reset in the middle of a frame.
        ssel_ = 1'b0;
        repeat (10) @(negedge clk);
        xfer(8'hFF, 4, rd);
        if (m_last != 8'h00) exp_chg_q.push_back(8'h00);
        rst = 1'b1;
        #1;
        check("midrst_byte", {24'd0, byte_data_recieved}, 32'd0);
        check("midrst_led", {31'd0, led}, 32'd0);
        check("midrst_miso", {31'd0, miso}, 32'd0);
        check("midrst_ssel_active", {31'd0, ssel_active}, 32'd0);
        ssel_ = 1'b1; sck = 1'b0;
        m_cnt = 8'h00; m_last = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        msg_q.push_back(8'hFF); msg_q.push_back(8'h00);
        send_msg();

        msg_q.push_back(8'h5A);
        send_msg();
        msg_q.push_back(8'h11);
        send_msg();

        // Long message that carries the reply count through 0xFF -> 0x00.
        for (int j = 0; j < 256; j++) msg_q.push_back(8'(j + 1));
        send_msg();

        msg_q.push_back(8'hC3);
        send_msg();

        repeat (20) @(negedge clk);
        check("chg_q_empty", exp_chg_q.size(), 32'd0);
        check("end_q_empty", exp_end_q.size(), 32'd0);
        check("miso_q_empty", exp_miso_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
